coi_decim_gen: RTL and testbench

Parametrised cascade-of-integrators (CoI) decimation filter for incremental sigma-delta ADC front-ends. Successor to the fixed third-order, single-shot, 1-bit integrator chain. Adds:
- configurable order and input width
- programmable conversion length
- single-shot or back-to-back continuous conversions
- valid-pulse output handshake

The block sits between the modulator bitstream and the readout/serial interface.

---
 rtl/coi_decim_gen.sv | 186 ++++++++++++++++++
 tb/tb_coi_decim_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/coi_decim_gen.sv
// ---------------------------------------------------------------------------
// coi_decim_gen
// Cascade-of-integrators decimation filter for incremental sigma-delta ADCs.
// A conversion integrates N modulator samples through ORDER cascaded
// integrators. The final integrator value is registered into d_out and
// announced with a one-cycle d_valid pulse. The block runs either single-shot
// (ends in DONE with a sticky done flag) or continuously (back-to-back
// conversions with no dead cycle until stop is seen).
//
// Parameters
//   ORDER  number of integrator stages (1..4)
//   IN_W   modulator sample width (unsigned)
//   N_W    width of the conversion-length field and the sample counter
//   OUT_W  IN_W + ORDER*N_W; stage k is IN_W + k*N_W bits wide
//
// Ports
//   clk       sample clock, rising edge
//   rstb_raw  asynchronous active-low reset; release is synchronised (2 flops)
//   start     begins a conversion when sampled in IDLE or DONE
//   stop      continuous mode: finish the current conversion, then go IDLE
//   mode      0 = single-shot, 1 = continuous (latched on accepted start)
//   n_in      samples per conversion, 0 means 1 (latched on accepted start)
//   d_in      modulator sample
//   d_out     last completed conversion result
//   d_valid   one-cycle pulse when d_out updates
//   busy      high while converting
//   done      single-shot completion flag, sticky until the next start
// ---------------------------------------------------------------------------
module coi_decim_gen #(
    parameter int ORDER = 3,
    parameter int IN_W  = 1,
    parameter int N_W   = 11,
    localparam int OUT_W = IN_W + ORDER * N_W
) (
    input  logic             clk,
    input  logic             rstb_raw,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [N_W-1:0]   n_in,
    input  logic [IN_W-1:0]  d_in,
    output logic [OUT_W-1:0] d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Reduce a full-width sum to the modular width of integrator stage k
    // (1-based). Stages are held at OUT_W bits but only the low
    // IN_W + k*N_W bits are meaningful.
    function automatic logic [OUT_W-1:0] stage_wrap(input logic [OUT_W-1:0] v,
                                                    input int k);
        logic [OUT_W-1:0] m;
        m = '0;
        for (int b = 0; b < OUT_W; b++) begin
            if (b < IN_W + k * N_W) m[b] = 1'b1;
        end
        return v & m;
    endfunction

    logic [1:0]       r_rst_sync;
    logic             w_rst_rel;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_mode;
    logic             r_stop;
    logic [N_W-1:0]   r_n;
    logic [N_W-1:0]   r_cnt;
    logic             r_dvalid;
    logic             r_done;
    logic [OUT_W-1:0] r_dout;
    logic [OUT_W-1:0] r_int     [ORDER];
    logic [OUT_W-1:0] w_int_nxt [ORDER];

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_stop_any;

    // Reset release synchroniser; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rstb_raw) begin
        if (!rstb_raw) r_rst_sync <= 2'b00;
        else           r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_rel = r_rst_sync[1];

    assign w_run      = (r_state == S_RUN);
    assign w_accept   = w_rst_rel && start && !w_run;
    assign w_last     = w_run && (r_cnt == (r_n - N_W'(1)));
    // A stop on the last-sample cycle itself still counts.
    assign w_stop_any = r_stop | stop;

    // Integrator ripple: every stage adds the *new* value of the stage below.
    always_comb begin
        for (int k = 0; k < ORDER; k++) w_int_nxt[k] = '0;
        w_int_nxt[0] = stage_wrap(r_int[0] + OUT_W'(d_in), 1);
        for (int k = 1; k < ORDER; k++) begin
            w_int_nxt[k] = stage_wrap(r_int[k] + w_int_nxt[k-1], k + 1);
        end
    end

    always_ff @(posedge clk or negedge rstb_raw) begin
        if (!rstb_raw) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_last) begin
                    if (!r_mode)         w_state_nxt = S_DONE;
                    else if (w_stop_any) w_state_nxt = S_IDLE;
                    else                 w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control: length/mode latch, sample counter, stop memory, flags.
    always_ff @(posedge clk or negedge rstb_raw) begin
        if (!rstb_raw) begin
            r_mode   <= 1'b0;
            r_stop   <= 1'b0;
            r_n      <= N_W'(1);
            r_cnt    <= '0;
            r_dvalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            if (w_accept) begin
                r_mode <= mode;
                r_n    <= (n_in == '0) ? N_W'(1) : n_in;
                r_cnt  <= '0;
                r_stop <= 1'b0;
                r_done <= 1'b0;
            end else if (w_run) begin
                if (w_last) begin
                    r_dvalid <= 1'b1;
                    r_cnt    <= '0;
                    r_stop   <= 1'b0;
                    r_done   <= !r_mode;
                end else begin
                    r_cnt  <= r_cnt + N_W'(1);
                    r_stop <= w_stop_any;
                end
            end
        end
    end

    // Datapath: integrators restart from zero right after the last sample so
    // a continuous conversion can take its first sample in the next cycle.
    always_ff @(posedge clk or negedge rstb_raw) begin
        if (!rstb_raw) begin
            r_dout <= '0;
            for (int k = 0; k < ORDER; k++) r_int[k] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < ORDER; k++) r_int[k] <= '0;
        end else if (w_run) begin
            if (w_last) begin
                r_dout <= w_int_nxt[ORDER-1];
                for (int k = 0; k < ORDER; k++) r_int[k] <= '0;
            end else begin
                for (int k = 0; k < ORDER; k++) r_int[k] <= w_int_nxt[k];
            end
        end
    end

    assign d_out   = r_dout;
    assign d_valid = r_dvalid;
    assign busy    = w_run;
    assign done    = r_done;

endmodule

// File: tb/tb_coi_decim_gen.sv
module tb_coi_decim_gen;

    localparam int N_W = 11;

    logic          clk = 1'b0;
    logic          rstb_raw;
    logic          start, stop, mode;
    logic [N_W-1:0] n_in;
    logic [0:0]    d_in;

    logic [11:0] d_out1;
    logic [22:0] d_out2;
    logic [33:0] d_out3;
    logic dv1, dv2, dv3, busy1, busy2, busy3, done1, done2, done3;

    int checks = 0;
    int errors = 0;

    bit smp [0:4095];

    always #5 clk = ~clk;

    coi_decim_gen #(.ORDER(1), .IN_W(1), .N_W(N_W)) u1 (
        .clk(clk), .rstb_raw(rstb_raw), .start(start), .stop(stop), .mode(mode),
        .n_in(n_in), .d_in(d_in), .d_out(d_out1), .d_valid(dv1), .busy(busy1), .done(done1));
    coi_decim_gen #(.ORDER(2), .IN_W(1), .N_W(N_W)) u2 (
        .clk(clk), .rstb_raw(rstb_raw), .start(start), .stop(stop), .mode(mode),
        .n_in(n_in), .d_in(d_in), .d_out(d_out2), .d_valid(dv2), .busy(busy2), .done(done2));
    coi_decim_gen #(.ORDER(3), .IN_W(1), .N_W(N_W)) u3 (
        .clk(clk), .rstb_raw(rstb_raw), .start(start), .stop(stop), .mode(mode),
        .n_in(n_in), .d_in(d_in), .d_out(d_out3), .d_valid(dv3), .busy(busy3), .done(done3));

    typedef struct {
        int     nv;    // value driven on n_in
        int     bits;  // bit i = sample i
        int     len;   // effective conversion length
        longint e1, e2, e3;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Binomial coefficient C(n,k); 0 outside the valid range.
    function automatic longint binom(input int n, input int k);
        longint r;
        r = 1;
        if (k < 0 || n < k) return 0;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // Closed-form CoI result for len samples starting at smp[base].
    function automatic longint model(input int order, input int len, input int base);
        longint s;
        longint m;
        s = 0;
        for (int i = 0; i < len; i++)
            if (smp[base + i]) s += binom(len - 1 - i + order - 1, order - 1);
        m = (longint'(1) <<< (1 + order * N_W)) - 1;
        return s & m;
    endfunction

    // Single-shot conversion of smp[0..len-1]; pokes start and n_in while busy.
    task automatic run_single(input int nv, input int len,
                              input longint e1, input longint e2, input longint e3,
                              input string tag);
        start = 1'b1; mode = 1'b0; stop = 1'b0; n_in = N_W'(nv);
        tick();
        start = 1'b0;
        for (int i = 0; i < len; i++) begin
            d_in  = smp[i];
            start = (i == 1);
            stop  = $urandom_range(0, 1);
            n_in  = N_W'($urandom);
            mode  = $urandom_range(0, 1);
            tick();
            chk({tag, "_dvalid"}, {dv3, dv2, dv1}, (i == len - 1) ? 3'b111 : 3'b000);
            chk({tag, "_busy"}, {busy3, busy2, busy1}, (i == len - 1) ? 3'b000 : 3'b111);
        end
        start = 1'b0; stop = 1'b0;
        chk({tag, "_dout1"}, d_out1, e1);
        chk({tag, "_dout2"}, d_out2, e2);
        chk({tag, "_dout3"}, d_out3, e3);
        chk({tag, "_done"}, {done3, done2, done1}, 3'b111);
        tick();
        chk({tag, "_dvalid_off"}, {dv3, dv2, dv1}, 3'b000);
        chk({tag, "_done_sticky"}, {done3, done2, done1}, 3'b111);
        chk({tag, "_idle_busy"}, {busy3, busy2, busy1}, 3'b000);
        chk({tag, "_dout_hold"}, d_out3, e3);
    endtask

    // Continuous run of nconv conversions over smp[c*len + i]; stop pulses once
    // inside the final conversion at index stop_idx.
    task automatic run_cont(input int len, input int nconv, input int stop_idx,
                            input string tag);
        bit last;
        start = 1'b1; mode = 1'b1; stop = 1'b0; n_in = N_W'(len);
        tick();
        start = 1'b0;
        for (int c = 0; c < nconv; c++) begin
            for (int i = 0; i < len; i++) begin
                d_in  = smp[c * len + i];
                stop  = (c == nconv - 1) && (i == stop_idx);
                n_in  = N_W'($urandom);
                mode  = $urandom_range(0, 1);
                start = $urandom_range(0, 1);
                tick();
                last = (i == len - 1);
                chk({tag, "_dvalid"}, {dv3, dv2, dv1}, last ? 3'b111 : 3'b000);
                chk({tag, "_busy"}, {busy3, busy2, busy1},
                    (last && c == nconv - 1) ? 3'b000 : 3'b111);
                chk({tag, "_done"}, {done3, done2, done1}, 3'b000);
                if (last) begin
                    chk({tag, "_dout1"}, d_out1, model(1, len, c * len));
                    chk({tag, "_dout2"}, d_out2, model(2, len, c * len));
                    chk({tag, "_dout3"}, d_out3, model(3, len, c * len));
                end
            end
        end
        start = 1'b0; stop = 1'b0; mode = 1'b0;
        tick();
        chk({tag, "_end_dvalid"}, {dv3, dv2, dv1}, 3'b000);
        chk({tag, "_end_busy"}, {busy3, busy2, busy1}, 3'b000);
        chk({tag, "_end_done"}, {done3, done2, done1}, 3'b000);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int len, nv, nconv, n_seen;
        bit got;

        vt[0] = '{4, 32'hF,  4, 4, 10, 20};
        vt[1] = '{4, 32'h1,  4, 1, 4, 10};
        vt[2] = '{0, 32'h1,  1, 1, 1, 1};
        vt[3] = '{1, 32'h0,  1, 0, 0, 0};
        vt[4] = '{5, 32'hB,  5, 3, 11, 28};
        vt[5] = '{3, 32'h4,  3, 1, 1, 1};
        vt[6] = '{6, 32'h3F, 6, 6, 21, 56};

        rstb_raw = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        n_in = '0; d_in = '0;
        #22;
        chk("reset_dout", {d_out3, d_out2, d_out1}, '0);
        chk("reset_flags", {dv3, dv2, dv1, busy3, busy2, busy1, done3, done2, done1}, '0);
        @(posedge clk); #1;
        rstb_raw = 1'b1;
        tick(); tick(); tick();
        chk("post_reset_idle", {busy3, busy2, busy1}, 3'b000);

        // Table-driven single-shot vectors.
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vt[v].len; i++) smp[i] = vt[v].bits[i];
            run_single(vt[v].nv, vt[v].len, vt[v].e1, vt[v].e2, vt[v].e3,
                       $sformatf("vec%0d", v));
        end

        // Long all-ones conversion.
        for (int i = 0; i < 1024; i++) smp[i] = 1'b1;
        run_single(1024, 1024, 1024, 524800, 179481600, "long1024");

        // Continuous all ones, stop inside the third conversion.
        for (int i = 0; i < 12; i++) smp[i] = 1'b1;
        run_cont(4, 3, 1, "cont_ones");

        // Randomised single-shot.
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 40);
            nv  = (len == 1 && $urandom_range(0, 1)) ? 0 : len;
            for (int i = 0; i < len; i++) smp[i] = $urandom_range(0, 1);
            run_single(nv, len, model(1, len, 0), model(2, len, 0), model(3, len, 0),
                       $sformatf("rnd_ss%0d", r));
        end

        // Randomised continuous.
        for (int r = 0; r < 4; r++) begin
            len   = $urandom_range(1, 30);
            nconv = $urandom_range(1, 4);
            for (int i = 0; i < len * nconv; i++) smp[i] = $urandom_range(0, 1);
            run_cont(len, nconv, $urandom_range(0, len - 1), $sformatf("rnd_ct%0d", r));
        end

        // Reset in the middle of a conversion.
        start = 1'b1; mode = 1'b0; n_in = N_W'(8); d_in = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rstb_raw = 1'b0;
        #1;
        chk("midrst_dout", {d_out3, d_out2, d_out1}, '0);
        chk("midrst_flags", {dv3, dv2, dv1, busy3, busy2, busy1, done3, done2, done1}, '0);
        tick(); tick();
        chk("midrst_no_dvalid", {dv3, dv2, dv1}, 3'b000);
        rstb_raw = 1'b1; start = 1'b1; n_in = N_W'(4); mode = 1'b0; d_in = 1'b1;
        tick();
        chk("rst_release_edge1", {busy3, busy2, busy1}, 3'b000);
        tick(); tick();
        chk("rst_release_accept", {busy3, busy2, busy1}, 3'b111);
        start = 1'b0;
        got = 1'b0;
        n_seen = 0;
        while (!got && n_seen < 12) begin
            tick();
            n_seen++;
            if (dv3) got = 1'b1;
        end
        chk("rst_release_dvalid_seen", got, 1'b1);
        chk("rst_release_dout1", d_out1, 4);
        chk("rst_release_dout2", d_out2, 10);
        chk("rst_release_dout3", d_out3, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
